// File: rtl/tron_pkg.sv
// Shared types and constants for the light-cycle datapath: directions,
// game-state encoding, keyboard map and keycode decoding helpers.
package tron_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_req_t;

    localparam logic [2:0] GS_PLAYING = 3'b010;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    // Opposite pairs differ only in bit 0 (00<->01, 10<->11).
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    function automatic key_req_t decode_key(
        input logic [7:0] code,
        input logic [7:0] k_up,
        input logic [7:0] k_down,
        input logic [7:0] k_left,
        input logic [7:0] k_right
    );
        key_req_t req;
        req = '{valid: 1'b1, dir: UP};
        if (code == k_up)         req.dir = UP;
        else if (code == k_down)  req.dir = DOWN;
        else if (code == k_left)  req.dir = LEFT;
        else if (code == k_right) req.dir = RIGHT;
        else                      req.valid = 1'b0;
        return req;
    endfunction

endpackage

// File: rtl/bike_stepper.sv
// One bike: pending-direction latch, position/direction registers,
// grid bound check and sticky wall flag.
module bike_stepper
    import tron_pkg::*;
#(
    parameter logic [7:0] START_X    = 8'd28,
    parameter logic [7:0] START_Y    = 8'd56,
    parameter dir_t       START_DIR  = RIGHT,
    parameter logic [7:0] CODE_UP    = KEY_W,
    parameter logic [7:0] CODE_DOWN  = KEY_S,
    parameter logic [7:0] CODE_LEFT  = KEY_A,
    parameter logic [7:0] CODE_RIGHT = KEY_D,
    parameter logic [7:0] GRID_MAX   = 8'd111
) (
    input  logic       Clk,
    input  logic       reinit,
    input  logic       run,
    input  logic       advance,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output dir_t       dir,
    output logic       wall
);

    dir_t       pending;
    key_req_t   req0, req1;
    logic       accept;
    dir_t       accept_dir;
    logic [7:0] next_x, next_y;
    logic       hit;

    assign req0 = decode_key(keycode0, CODE_UP, CODE_DOWN, CODE_LEFT, CODE_RIGHT);
    assign req1 = decode_key(keycode1, CODE_UP, CODE_DOWN, CODE_LEFT, CODE_RIGHT);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        accept     = 1'b0;
        accept_dir = pending;
        if (req0.valid && req0.dir != opposite(dir)) begin
            accept     = 1'b1;
            accept_dir = req0.dir;
        end else if (req1.valid && req1.dir != opposite(dir)) begin
            accept     = 1'b1;
            accept_dir = req1.dir;
        end
    end

    // Bounds are tested before the update so a coordinate never wraps through 8'hFF.
    always_comb begin
        next_x = pos_x;
        next_y = pos_y;
        hit    = 1'b0;
        case (pending)
            UP:    if (pos_y == 8'd0)     hit = 1'b1; else next_y = pos_y - 8'd1;
            DOWN:  if (pos_y >= GRID_MAX) hit = 1'b1; else next_y = pos_y + 8'd1;
            LEFT:  if (pos_x == 8'd0)     hit = 1'b1; else next_x = pos_x - 8'd1;
            RIGHT: if (pos_x >= GRID_MAX) hit = 1'b1; else next_x = pos_x + 8'd1;
            default: hit = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (reinit) begin
            pos_x   <= START_X;
            pos_y   <= START_Y;
            dir     <= START_DIR;
            pending <= START_DIR;
            wall    <= 1'b0;
        end else if (run) begin
            if (advance) begin
                dir   <= pending;
                pos_x <= next_x;
                pos_y <= next_y;
                if (hit) wall <= 1'b1;
            end else if (accept) begin
                pending <= accept_dir;
            end
        end
    end

endmodule

// File: rtl/bike_motion.sv
// Frame-strobe synchroniser, step timing and game FSM driving the two
// bike_stepper instances that feed the trail writer.
module bike_motion
    import tron_pkg::*;
#(
    parameter int         FRAMES_PER_STEP = 2,
    parameter logic [7:0] GRID_MAX        = 8'd111,
    parameter logic [7:0] BLUE_START_X    = 8'd28,
    parameter logic [7:0] RED_START_X     = 8'd84,
    parameter logic [7:0] START_Y         = 8'd56
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [2:0] Game_State,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [7:0] Blue_X,
    output logic [7:0] Blue_Y,
    output logic [7:0] Red_X,
    output logic [7:0] Red_Y,
    output logic [1:0] Blue_dir,
    output logic [1:0] Red_dir,
    output logic       step,
    output logic       Blue_wall,
    output logic       Red_wall
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_CRASH = 2'b10;

    localparam logic [3:0] LAST_FRAME = 4'(FRAMES_PER_STEP - 1);

    logic [1:0] state;
    logic [3:0] frame_cnt;
    logic       frame_meta, frame_sync, frame_prev, frame_tick;
    logic       reinit, running, any_wall, advance;

    assign reinit   = Reset || (Game_State != GS_PLAYING);
    assign running  = (state == S_RUN);
    assign any_wall = Blue_wall || Red_wall;
    assign advance  = running && !any_wall && frame_tick && (frame_cnt == LAST_FRAME);

    // frame_clk is asynchronous: two flops, then a registered rising-edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_meta <= 1'b0;
            frame_sync <= 1'b0;
            frame_prev <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_meta <= frame_clk;
            frame_sync <= frame_meta;
            frame_prev <= frame_sync;
            frame_tick <= frame_sync && !frame_prev;
        end
    end

    always_ff @(posedge Clk) begin
        if (reinit) begin
            state     <= S_IDLE;
            frame_cnt <= 4'd0;
            step      <= 1'b0;
        end else begin
            step <= advance;
            case (state)
                S_IDLE:  state <= S_RUN;
                S_RUN: begin
                    if (any_wall) begin
                        state <= S_CRASH;
                    end else if (frame_tick) begin
                        frame_cnt <= advance ? 4'd0 : frame_cnt + 4'd1;
                    end
                end
                S_CRASH: state <= S_CRASH;
                default: state <= S_IDLE;
            endcase
        end
    end

    bike_stepper #(
        .START_X(BLUE_START_X), .START_Y(START_Y), .START_DIR(RIGHT),
        .CODE_UP(KEY_W), .CODE_DOWN(KEY_S), .CODE_LEFT(KEY_A), .CODE_RIGHT(KEY_D),
        .GRID_MAX(GRID_MAX)
    ) u_blue (
        .Clk(Clk), .reinit(reinit), .run(running), .advance(advance),
        .keycode0(keycode0), .keycode1(keycode1),
        .pos_x(Blue_X), .pos_y(Blue_Y), .dir(Blue_dir), .wall(Blue_wall)
    );

    bike_stepper #(
        .START_X(RED_START_X), .START_Y(START_Y), .START_DIR(LEFT),
        .CODE_UP(KEY_UP), .CODE_DOWN(KEY_DOWN), .CODE_LEFT(KEY_LEFT), .CODE_RIGHT(KEY_RIGHT),
        .GRID_MAX(GRID_MAX)
    ) u_red (
        .Clk(Clk), .reinit(reinit), .run(running), .advance(advance),
        .keycode0(keycode0), .keycode1(keycode1),
        .pos_x(Red_X), .pos_y(Red_Y), .dir(Red_dir), .wall(Red_wall)
    );

endmodule

// File: tb/tb_bike_motion.sv
// Directed bench for bike_motion: table of key/frame vectors plus hand-written
// wall, crash and reinit sequences, all expectations computed here.
module tb_bike_motion;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [2:0] Game_State;
    logic [7:0] keycode0, keycode1;
    logic [7:0] Blue_X, Blue_Y, Red_X, Red_Y;
    logic [1:0] Blue_dir, Red_dir;
    logic       step, Blue_wall, Red_wall;

    int checks   = 0;
    int failures = 0;
    int step_count = 0;

    bike_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .keycode0(keycode0), .keycode1(keycode1),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .Blue_dir(Blue_dir), .Red_dir(Red_dir), .step(step),
        .Blue_wall(Blue_wall), .Red_wall(Red_wall)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (step === 1'b1) step_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] k0a, k1a, k0b, k1b;
        int         frames;
        int         bx, by, bd, rx, ry, rd;
        int         steps;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic press(input logic [7:0] a, input logic [7:0] b);
        @(negedge Clk);
        keycode0 = a;
        keycode1 = b;
        repeat (2) @(negedge Clk);
        keycode0 = 8'h00;
        keycode1 = 8'h00;
    endtask

    task automatic frame_edge();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    task automatic check_start(input string tag);
        check({tag, " blue_x"}, Blue_X, 28);
        check({tag, " blue_y"}, Blue_Y, 56);
        check({tag, " blue_dir"}, Blue_dir, 3);
        check({tag, " red_x"}, Red_X, 84);
        check({tag, " red_y"}, Red_Y, 56);
        check({tag, " red_dir"}, Red_dir, 2);
        check({tag, " step"}, step, 0);
        check({tag, " walls"}, {Blue_wall, Red_wall}, 0);
    endtask

    initial begin
        int base, bx, by, rx, ry;

        // {k0a, k1a, k0b, k1b, frames, bx, by, bd, rx, ry, rd, steps}
        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 4, 30, 56, 3, 82, 56, 2, 2};
        vecs[1] = '{8'h04, 8'h00, 8'h1A, 8'h00, 2, 30, 55, 0, 81, 56, 2, 1};
        vecs[2] = '{8'h04, 8'h00, 8'h00, 8'h00, 2, 29, 55, 2, 80, 56, 2, 1};
        vecs[3] = '{8'h1A, 8'h16, 8'h00, 8'h00, 2, 29, 54, 0, 79, 56, 2, 1};
        vecs[4] = '{8'h07, 8'h52, 8'h00, 8'h00, 2, 30, 54, 3, 79, 55, 0, 1};
        vecs[5] = '{8'h16, 8'h4F, 8'h00, 8'h00, 2, 30, 55, 1, 80, 55, 3, 1};
        vecs[6] = '{8'h50, 8'h00, 8'h00, 8'h00, 2, 30, 56, 1, 81, 55, 3, 1};

        Reset = 1'b1;
        frame_clk = 1'b0;
        Game_State = 3'b000;
        keycode0 = 8'h00;
        keycode1 = 8'h00;
        @(negedge Clk);
        Reset = 1'b0;
        check_start("reset");

        Game_State = 3'b010;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 7; i++) begin
            base = step_count;
            press(vecs[i].k0a, vecs[i].k1a);
            if (vecs[i].k0b != 8'h00 || vecs[i].k1b != 8'h00)
                press(vecs[i].k0b, vecs[i].k1b);
            for (int f = 0; f < vecs[i].frames; f++) frame_edge();
            check($sformatf("v%0d blue_x", i), Blue_X, vecs[i].bx);
            check($sformatf("v%0d blue_y", i), Blue_Y, vecs[i].by);
            check($sformatf("v%0d blue_dir", i), Blue_dir, vecs[i].bd);
            check($sformatf("v%0d red_x", i), Red_X, vecs[i].rx);
            check($sformatf("v%0d red_y", i), Red_Y, vecs[i].ry);
            check($sformatf("v%0d red_dir", i), Red_dir, vecs[i].rd);
            check($sformatf("v%0d steps", i), step_count - base, vecs[i].steps);
        end

        // Red turns up then runs left into the x=0 wall; blue zig-zags right/down.
        bx = 30; by = 56; rx = 81; ry = 55;
        base = step_count;
        for (int k = 0; k < 83; k++) begin
            press((k % 2 == 0) ? 8'h07 : 8'h16, (k == 0) ? 8'h52 : 8'h50);
            frame_edge();
            frame_edge();
            if (k % 2 == 0) bx++; else by++;
            if (k == 0) ry--;
            else if (rx > 0) rx--;
            if (k == 81) begin
                check("red reaches x0", Red_X, 0);
                check("red no wall at x0", Red_wall, 0);
            end
        end
        check("wall red_x held", Red_X, rx);
        check("wall red_y", Red_Y, ry);
        check("wall red_flag", Red_wall, 1);
        check("wall blue_flag", Blue_wall, 0);
        check("wall blue_x", Blue_X, bx);
        check("wall blue_y", Blue_Y, by);
        check("wall steps", step_count - base, 83);

        // CRASH: keys and frames have no effect.
        repeat (2) @(negedge Clk);
        base = step_count;
        press(8'h1A, 8'h52);
        for (int f = 0; f < 4; f++) frame_edge();
        check("crash steps", step_count - base, 0);
        check("crash blue_x", Blue_X, bx);
        check("crash blue_y", Blue_Y, by);
        check("crash blue_dir", Blue_dir, 3);
        check("crash red_x", Red_X, 0);
        check("crash red_dir", Red_dir, 2);
        check("crash red_flag", Red_wall, 1);

        Game_State = 3'b000;
        repeat (2) @(negedge Clk);
        check_start("reinit");

        // Leave playing exactly on the cycle the step tick is consumed.
        Game_State = 3'b010;
        repeat (2) @(negedge Clk);
        base = step_count;
        frame_edge();
        check("pre-coincide steps", step_count - base, 0);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        Game_State = 3'b000;
        @(negedge Clk);
        check("coincide steps", step_count - base, 0);
        check_start("coincide");
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);

        Game_State = 3'b010;
        repeat (2) @(negedge Clk);
        frame_edge();
        check("counter cleared no step", step_count - base, 0);
        check("counter cleared blue_x", Blue_X, 28);
        frame_edge();
        check("restart steps", step_count - base, 1);
        check("restart blue_x", Blue_X, 29);
        check("restart red_x", Red_X, 83);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
